uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
Upstream stage of the UART controller. Holds a fixed multi-byte message and feeds it one byte at a time to the controller's Tx_DATA/Tx_WR/Tx_EN inputs. Paces each write on the controller's Tx_BUSY. Flags a stall if the transmitter never accepts a byte.

Parameters:
MSG_LEN, 4, number of bytes in the message (1..16)
MSG, 32'h89CC55AA, message contents, width 8*MSG_LEN; byte 0 = MSG[7:0], sent first
GAP_CYCLES, 16, idle clk cycles inserted after Tx_BUSY falls before the next write (0 allowed)
TIMEOUT_CYCLES, 1024, max cycles to wait for Tx_BUSY to rise after a write

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
start  in  1  level; sampled in IDLE, begins a message
Tx_BUSY  in  1  busy flag from the controller
Tx_DATA  out  8  byte presented to the controller
Tx_WR  out  1  one-cycle write strobe
Tx_EN  out  1  transmitter enable, high from LOAD until return to IDLE
byte_idx  out  4  index of the byte currently in flight
done  out  1  one-cycle pulse after the last byte completes
stall  out  1  sticky; set on timeout

Behaviour:
- Reset values: Tx_DATA=0, Tx_WR=0, Tx_EN=0, byte_idx=0, done=0, stall=0; state=IDLE; all counters=0. Reset mid-message aborts immediately with no partial strobe.
- All outputs are registered.
- State machine:
  - IDLE: if start && !stall -> LOAD.
  - LOAD: Tx_EN=1; Tx_DATA=MSG[8*byte_idx+:8]; if !Tx_BUSY -> WRITE, else stay.
  - WRITE: Tx_WR=1 for exactly this cycle; Tx_DATA held; timeout counter cleared -> WAIT_HI.
  - WAIT_HI: wait for Tx_BUSY=1 -> WAIT_LO. Counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 with Tx_BUSY still 0: set stall, Tx_EN=0 -> IDLE.
  - WAIT_LO: wait for Tx_BUSY=0 -> GAP. No timeout in this state.
  - GAP: count GAP_CYCLES cycles; GAP_CYCLES=0 means zero cycles, go straight on. Then:
    - byte_idx != MSG_LEN-1: byte_idx+1 -> LOAD.
    - last byte: done=1 for one cycle, byte_idx=0, Tx_EN=0 -> IDLE.
- Tx_DATA stays stable from LOAD until the next LOAD, so the controller latches a clean value on Tx_WR.
- Tx_WR never asserts while Tx_BUSY=1, and never on two consecutive cycles.
- start is ignored outside IDLE. A start held high through IDLE begins a new message on the cycle after done (one-shot build only).
- stall clears only on reset. While stall=1, start is ignored.
- byte_idx width 4 bits; wraps only via the explicit last-byte rule, never by overflow.
- If Tx_BUSY is high and drops in the same cycle WRITE is entered, the write still issues; the WAIT_HI timeout covers a missed handshake.

Optional Feature:
Macro SEQ_REPEAT_EN.
- Defined: at the last byte's GAP end, done pulses and byte_idx=0. If start is still high, go to LOAD directly with Tx_EN kept at 1 (continuous repeating stream). If start is low, go to IDLE.
- Not defined: always return to IDLE after the last byte. Tx_EN drops for at least one cycle between messages.

Test Plan:
- Single message: reset, start=1 for 1 cycle, behavioural Tx_BUSY model goes high 2 cycles after Tx_WR and stays high 20 cycles -> Tx_DATA sequence AA,55,CC,89; four Tx_WR pulses spaced 2+20+16+2 cycles; one done pulse; stall=0.
- Busy at start: Tx_BUSY=1 when start asserts, released 50 cycles later -> no Tx_WR before release; first Tx_WR on the 2nd cycle after Tx_BUSY=0.
- Timeout: Tx_BUSY tied 0 -> stall=1 exactly TIMEOUT_CYCLES cycles after the first Tx_WR; Tx_EN=0; later start pulses produce no Tx_WR.
- Mid-message reset: assert reset during byte 2's WAIT_LO -> all outputs return to reset values asynchronously. Next start begins at byte 0 (AA).
- GAP_CYCLES=0 variant: Tx_WR follows Tx_BUSY fall by exactly 2 cycles (GAP->LOAD->WRITE).
- With SEQ_REPEAT_EN and start held high -> AA,55,CC,89,AA,... continuously, done every 4 bytes, Tx_EN never drops. Without it -> Tx_EN low for at least 1 cycle between messages.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// Sends a fixed MSG_LEN-byte message to a UART controller, one byte per Tx_WR strobe paced by Tx_BUSY.
// Optional build macro SEQ_REPEAT_EN: when start is still high at the end of a message, the message repeats with Tx_EN held high.
module uart_tx_sequencer #(
    parameter int unsigned          MSG_LEN        = 4,
    parameter logic [8*MSG_LEN-1:0] MSG            = 32'h89CC55AA,
    parameter int unsigned          GAP_CYCLES     = 16,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       Tx_BUSY,
    output logic [7:0] Tx_DATA,
    output logic       Tx_WR,
    output logic       Tx_EN,
    output logic [3:0] byte_idx,
    output logic       done,
    output logic       stall
);

    localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [3:0]  LAST_IDX = 4'(MSG_LEN - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          tx_en_q, tx_en_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic          done_q, done_d;
    logic          stall_q, stall_d;
    logic          gap_end;

    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        msg_byte = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (idx == 4'(i)) begin
                msg_byte = MSG[8*i +: 8];
            end
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + CW'(1);
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        tx_en_d    = tx_en_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        stall_d    = stall_q;
        gap_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stall_q) begin
                    state_d   = S_LOAD;
                    tx_en_d   = 1'b1;
                    tx_data_d = msg_byte(byte_idx_q);
                end
            end
            S_LOAD: begin
                if (!Tx_BUSY) begin
                    state_d = S_WRITE;
                    tx_wr_d = 1'b1;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // Stall is flagged in the cycle the counter would become TIMEOUT_CYCLES-1.
                if (Tx_BUSY) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_inc == TO_LAST) begin
                    stall_d = 1'b1;
                    tx_en_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_LO: begin
                if (!Tx_BUSY) begin
                    if (GAP_CYCLES == 0) begin
                        gap_end = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    gap_end = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (gap_end) begin
            cnt_d = '0;
            if (byte_idx_q == LAST_IDX) begin
                done_d     = 1'b1;
                byte_idx_d = '0;
`ifdef SEQ_REPEAT_EN
                if (start) begin
                    state_d   = S_LOAD;
                    tx_data_d = msg_byte(4'd0);
                end else begin
                    state_d = S_IDLE;
                    tx_en_d = 1'b0;
                end
`else
                state_d = S_IDLE;
                tx_en_d = 1'b0;
`endif
            end else begin
                byte_idx_d = byte_idx_q + 4'd1;
                tx_data_d  = msg_byte(byte_idx_q + 4'd1);
                state_d    = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            byte_idx_q <= '0;
            done_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            tx_en_q    <= tx_en_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
            stall_q    <= stall_d;
        end
    end

    assign Tx_DATA  = tx_data_q;
    assign Tx_WR    = tx_wr_q;
    assign Tx_EN    = tx_en_q;
    assign byte_idx = byte_idx_q;
    assign done     = done_q;
    assign stall    = stall_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: default instance plus a GAP_CYCLES=0 instance.
// Honours SEQ_REPEAT_EN for the message-boundary expectations.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, Tx_BUSY;
    logic [7:0] Tx_DATA;
    logic       Tx_WR, Tx_EN, done, stall;
    logic [3:0] byte_idx;

    logic       start0, busy0;
    logic [7:0] data_0;
    logic       wr_0, en_0, done_0, stall_0;
    logic [3:0] idx_0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .MSG_LEN(4), .MSG(32'h89CC55AA), .GAP_CYCLES(16), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .Tx_BUSY(Tx_BUSY),
        .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .byte_idx(byte_idx), .done(done), .stall(stall)
    );

    uart_tx_sequencer #(
        .MSG_LEN(4), .MSG(32'h89CC55AA), .GAP_CYCLES(0), .TIMEOUT_CYCLES(1024)
    ) dut_nogap (
        .clk(clk), .reset(reset), .start(start0), .Tx_BUSY(busy0),
        .Tx_DATA(data_0), .Tx_WR(wr_0), .Tx_EN(en_0),
        .byte_idx(idx_0), .done(done_0), .stall(stall_0)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] msg_b [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};
    logic [7:0] exp_q [$];
    int         wr_times [$];
    int         done_times [$];
    logic       done_en [$];
    int         wr0_times [$];
    int         fall0 [$];
    int         done0_times [$];
    logic [7:0] data0 [$];
    logic       wr_prev = 1'b0;
    logic       model_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_msg();
        for (int i = 0; i < 4; i++) exp_q.push_back(msg_b[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (wr_times.size() >= target) break;
        end
        check({tag, "_wr_seen"}, 32'(wr_times.size() >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_times.size() >= target) break;
        end
        check({tag, "_done_seen"}, 32'(done_times.size() >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  Tx_DATA, 0);
        check({tag, "_wr"},    Tx_WR, 0);
        check({tag, "_en"},    Tx_EN, 0);
        check({tag, "_idx"},   byte_idx, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: each write strobe pops the next expected byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (Tx_WR) begin
                check("wr_back_to_back", 32'(wr_prev), 0);
                check("wr_while_busy", 32'(Tx_BUSY), 0);
                check("wr_tx_en", 32'(Tx_EN), 1);
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("tx_data", Tx_DATA, exp_q.pop_front());
                wr_times.push_back(cyc);
            end
            if (done) begin
                done_times.push_back(cyc);
                done_en.push_back(Tx_EN);
            end
            wr_prev = Tx_WR;
        end else begin
            wr_prev = 1'b0;
        end
        if (!reset) begin
            if (wr_0) begin
                wr0_times.push_back(cyc);
                data0.push_back(data_0);
            end
            if (done_0) done0_times.push_back(cyc);
        end
    end

    // Controller model: busy rises 2 cycles after the strobe and stays high 20 cycles.
    initial forever begin
        @(negedge clk);
        if (model_en && Tx_WR && !reset) begin
            @(posedge clk); @(posedge clk); #1 Tx_BUSY = 1'b1;
            repeat (20) @(posedge clk);
            #1 Tx_BUSY = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (wr_0 && !reset) begin
            @(posedge clk); @(posedge clk); #1 busy0 = 1'b1;
            repeat (20) @(posedge clk);
            #1 busy0 = 1'b0;
            fall0.push_back(cyc);
        end
    end

    initial begin
        int s, r, n_wr, n_done, st, n0;
        reset = 1'b1; start = 1'b0; Tx_BUSY = 1'b0; start0 = 1'b0; busy0 = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Single message with one-cycle start.
        model_en = 1'b1;
        n_wr = wr_times.size(); n_done = done_times.size();
        push_msg();
        s = cyc;
        pulse_start();
        wait_done(n_done + 1, 400, "single");
        tick(30);
        check("single_wr_count", wr_times.size() - n_wr, 4);
        check("single_first_wr", wr_times[n_wr] - s, 2);
        for (int k = 1; k < 4; k++) check("single_wr_spacing", wr_times[n_wr + k] - wr_times[n_wr + k - 1], 40);
        check("single_done_time", done_times[n_done] - wr_times[n_wr + 3], 39);
        check("single_done_count", done_times.size() - n_done, 1);
        check("single_stall", stall, 0);
        check("single_en_after", Tx_EN, 0);
        check("single_idx_after", byte_idx, 0);
        check("single_data_held", Tx_DATA, 8'h89);

        // Start held across a message boundary.
        n_wr = wr_times.size(); n_done = done_times.size();
        push_msg(); push_msg();
        start = 1'b1;
        wait_wr(n_wr + 5, 400, "held");
        tick(1);
        start = 1'b0;
        wait_done(n_done + 2, 400, "held");
        tick(60);
        check("held_wr_count", wr_times.size() - n_wr, 8);
        check("held_done_count", done_times.size() - n_done, 2);
`ifdef SEQ_REPEAT_EN
        check("held_en_at_done", 32'(done_en[n_done]), 1);
        check("held_restart_wr", wr_times[n_wr + 4] - done_times[n_done], 1);
`else
        check("held_en_at_done", 32'(done_en[n_done]), 0);
        check("held_restart_wr", wr_times[n_wr + 4] - done_times[n_done], 2);
`endif
        check("held_queue_empty", exp_q.size(), 0);

        // Controller busy when start arrives.
        model_en = 1'b0;
        Tx_BUSY = 1'b1;
        n_wr = wr_times.size(); n_done = done_times.size();
        push_msg();
        pulse_start();
        tick(50);
        check("busy_no_wr", wr_times.size() - n_wr, 0);
        check("busy_en_load", Tx_EN, 1);
        check("busy_data_load", Tx_DATA, 8'hAA);
        Tx_BUSY = 1'b0;
        r = cyc;
        model_en = 1'b1;
        wait_wr(n_wr + 1, 10, "busy");
        check("busy_first_wr", wr_times[n_wr] - r, 1);
        wait_done(n_done + 1, 400, "busy");
        tick(5);

        // Reset while the third byte is in WAIT_LO.
        n_wr = wr_times.size();
        push_msg();
        pulse_start();
        wait_wr(n_wr + 3, 300, "midrst");
        tick(10);
        check("midrst_idx", byte_idx, 2);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        tick(3);
        reset = 1'b0;
        tick(20);
        n_wr = wr_times.size(); n_done = done_times.size();
        push_msg();
        s = cyc;
        pulse_start();
        wait_done(n_done + 1, 400, "midrst");
        check("midrst_first_wr", wr_times[n_wr] - s, 2);
        check("midrst_wr_count", wr_times.size() - n_wr, 4);
        tick(5);

        // GAP_CYCLES=0 instance: write follows busy fall by 2 cycles.
        n0 = done0_times.size();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (done0_times.size() > n0) break;
        end
        check("nogap_done_seen", 32'(done0_times.size() > n0), 1);
        check("nogap_wr_count", wr0_times.size(), 4);
        for (int k = 0; k < 4; k++) check("nogap_data", data0[k], msg_b[k]);
        for (int k = 1; k < 4; k++) check("nogap_fall_to_wr", wr0_times[k] - fall0[k - 1], 2);
        tick(5);

        // Timeout: busy never rises.
        model_en = 1'b0;
        Tx_BUSY = 1'b0;
        n_wr = wr_times.size();
        exp_q.push_back(8'hAA);
        pulse_start();
        st = -1;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk); #1;
            if (stall) begin
                st = cyc;
                break;
            end
        end
        check("timeout_stall", stall, 1);
        check("timeout_latency", st - wr_times[n_wr], 1024);
        check("timeout_en", Tx_EN, 0);
        check("timeout_one_wr", wr_times.size() - n_wr, 1);
        pulse_start();
        tick(50);
        check("stalled_no_wr", wr_times.size() - n_wr, 1);
        check("stalled_sticky", stall, 1);
        reset = 1'b1;
        #1;
        check("reset_clears_stall", stall, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
